smvm_result_collector: RTL

//  Downstream of the SMVM core. Takes the core's 14-bit half-word output stream
//  (high half first, then low half, per row), rebuilds 28-bit signed row

---
 rtl/smvm_result_collector.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/smvm_result_collector.sv
// Rebuilds 28-bit signed SMVM row results from high/low half-words, tags them with
// their row index and buffers them in a FIFO for a valid/ready host port.
module smvm_result_collector #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3,
    parameter int unsigned HW    = 14,
    parameter int unsigned DW    = 28,
    parameter int unsigned RW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [RW-1:0] rows_total,
    input  logic          in_valid,
    input  logic [HW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [RW-1:0] out_row,
    output logic          out_last,
    output logic          busy,
    output logic          done,
    output logic          overflow,
    output logic          proto_err
);

    typedef enum logic [1:0] {StIdle, StCollect, StDrain, StDone} state_e;

    localparam int unsigned EW = DW + RW + 1;

    state_e        state_q, state_d;
    logic [RW-1:0] rows_total_q, rows_total_d;
    logic [RW-1:0] row_cnt_q, row_cnt_d;
    logic [RW-1:0] row_cnt_inc;
    logic          phase_q, phase_d;  // 0: expecting high half, 1: expecting low half
    logic [HW-1:0] hi_q, hi_d;
    logic          overflow_q, overflow_d;
    logic          proto_err_q, proto_err_d;

    logic [AW:0]   wptr_q, wptr_d;
    logic [AW:0]   rptr_q, rptr_d;
    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] head;
    logic          empty, full, pop, push_req, push, row_last;

    assign empty    = (wptr_q == rptr_q);
    assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop      = !empty && out_ready;
    assign push_req = (state_q == StCollect) && in_valid && phase_q;
    // A full FIFO still accepts the push when the head leaves on the same edge.
    assign push     = push_req && (!full || pop);

    assign row_cnt_inc = row_cnt_q + RW'(1);
    assign row_last    = (row_cnt_q == rows_total_q - RW'(1));

    assign wptr_d = wptr_q + {{AW{1'b0}}, push};
    assign rptr_d = rptr_q + {{AW{1'b0}}, pop};

    always_comb begin
        state_d      = state_q;
        rows_total_d = rows_total_q;
        row_cnt_d    = row_cnt_q;
        phase_d      = phase_q;
        hi_d         = hi_q;
        overflow_d   = overflow_q;
        proto_err_d  = proto_err_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    rows_total_d = rows_total;
                    row_cnt_d    = '0;
                    phase_d      = 1'b0;
                    overflow_d   = 1'b0;
                    proto_err_d  = 1'b0;
                    state_d      = (rows_total == '0) ? StDone : StCollect;
                end
            end
            StCollect: begin
                if (in_valid) begin
                    if (!phase_q) begin
                        hi_d    = in_data;
                        phase_d = 1'b1;
                    end else begin
                        phase_d   = 1'b0;
                        row_cnt_d = row_cnt_inc;
                        if (!push) begin
                            overflow_d = 1'b1;
                        end
                        if (row_cnt_inc == rows_total_q) begin
                            state_d = StDrain;
                        end
                    end
                end
            end
            StDrain: begin
                if (empty) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Stray half-words are flagged even if they coincide with a start.
        if (in_valid && (state_q != StCollect)) begin
            proto_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            rows_total_q <= '0;
            row_cnt_q    <= '0;
            phase_q      <= 1'b0;
            hi_q         <= '0;
            overflow_q   <= 1'b0;
            proto_err_q  <= 1'b0;
            wptr_q       <= '0;
            rptr_q       <= '0;
        end else begin
            state_q      <= state_d;
            rows_total_q <= rows_total_d;
            row_cnt_q    <= row_cnt_d;
            phase_q      <= phase_d;
            hi_q         <= hi_d;
            overflow_q   <= overflow_d;
            proto_err_q  <= proto_err_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q[AW-1:0]] <= {row_last, row_cnt_q, hi_q, in_data};
        end
    end

    assign head = mem_q[rptr_q[AW-1:0]];

    // Head fields are masked while empty so stale or uninitialised entries never show.
    assign out_valid = !empty;
    assign out_data  = out_valid ? head[DW-1:0] : '0;
    assign out_row   = out_valid ? head[DW+RW-1:DW] : '0;
    assign out_last  = out_valid && head[EW-1];
    assign busy      = (state_q == StCollect) || (state_q == StDrain);
    assign done      = (state_q == StDone);
    assign overflow  = overflow_q;
    assign proto_err = proto_err_q;

endmodule
